// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the GF(2^163) ALU sequencer.
package alu_seq_pkg;
    localparam int FIELD_W   = 163;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 2 ** REG_IDX_W;
    localparam int OP_W      = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = 3'd0;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD   = 3'd2;
    localparam logic [OP_W-1:0] OP_SQADD = 3'd3;
    localparam logic [OP_W-1:0] OP_SQSQ  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WB
    } state_t;
endpackage

// File: rtl/alu_seq_regfile.sv
// 8 x FIELD_W register bank: one write port, two registered operand reads, one combinational host read.
module alu_seq_regfile
    import alu_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [FIELD_W-1:0]   wdata,
    input  logic                 rd_en,
    input  logic [REG_IDX_W-1:0] srca,
    input  logic [REG_IDX_W-1:0] srcb,
    output logic [FIELD_W-1:0]   da,
    output logic [FIELD_W-1:0]   db,
    input  logic [REG_IDX_W-1:0] rd_addr,
    output logic [FIELD_W-1:0]   rd_data
);
    logic [FIELD_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            da <= '0;
            db <= '0;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            // Operands are snapshotted at accept, so dst == src is safe.
            if (rd_en) begin
                da <= regs[srca];
                db <= regs[srcb];
            end
        end
    end

    assign rd_data = regs[rd_addr];
endmodule

// File: rtl/alu_sequencer.sv
// Single-issue sequencer: accepts one instruction, drives the external GF ALU, writes back and pulses done.
// state  | meaning
// IDLE   | ready for an instruction
// EXEC   | waiting out ALU latency (countdown)
// WB     | result written at end of cycle, done high
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MUL_LAT = 164,
    parameter int SQA_LAT = 2,
    parameter int SS_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OP_W-1:0]      instr_op,
    input  logic [REG_IDX_W-1:0] instr_dst,
    input  logic [REG_IDX_W-1:0] instr_srca,
    input  logic [REG_IDX_W-1:0] instr_srcb,
    input  logic [FIELD_W-1:0]   load_data,
    output logic                 done,
    output logic                 err_illegal,
    input  logic [REG_IDX_W-1:0] rd_addr,
    output logic [FIELD_W-1:0]   rd_data,
    output logic [FIELD_W-1:0]   DA,
    output logic [FIELD_W-1:0]   DB,
    output logic                 Mul_enable,
    output logic                 SQA_opt,
    input  logic [FIELD_W-1:0]   BP_OUT1,
    input  logic [FIELD_W-1:0]   BP_OUT2,
    input  logic [FIELD_W-1:0]   SS_OUT
);
    localparam int MAX_LAT = (MUL_LAT > SQA_LAT) ? ((MUL_LAT > SS_LAT) ? MUL_LAT : SS_LAT)
                                                 : ((SQA_LAT > SS_LAT) ? SQA_LAT : SS_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [OP_W-1:0]        op_q;
    logic [REG_IDX_W-1:0]   dst_q;
    logic [FIELD_W-1:0]     result;
    logic                   accept;
    logic                   wb_we;

    assign instr_ready = (state == S_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign wb_we       = (state == S_WB) && !err_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op_q        <= OP_LOAD;
            dst_q       <= '0;
            result      <= '0;
            Mul_enable  <= 1'b0;
            SQA_opt     <= 1'b0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= instr_op;
                        dst_q <= instr_dst;
                        case (instr_op)
                            OP_LOAD: begin
                                result <= load_data;
                                done   <= 1'b1;
                                state  <= S_WB;
                            end
                            OP_MUL: begin
                                cnt        <= CNT_W'(MUL_LAT - 1);
                                Mul_enable <= 1'b1;
                                state      <= S_EXEC;
                            end
                            OP_ADD: begin
                                cnt   <= CNT_W'(SQA_LAT - 1);
                                state <= S_EXEC;
                            end
                            OP_SQADD: begin
                                cnt     <= CNT_W'(SQA_LAT - 1);
                                SQA_opt <= 1'b1;
                                state   <= S_EXEC;
                            end
                            OP_SQSQ: begin
                                cnt   <= CNT_W'(SS_LAT - 1);
                                state <= S_EXEC;
                            end
                            default: begin
                                done        <= 1'b1;
                                err_illegal <= 1'b1;
                                state       <= S_WB;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        if (op_q == OP_MUL) begin
                            result <= BP_OUT1;
                        end else if (op_q == OP_SQSQ) begin
                            result <= SS_OUT;
                        end else begin
                            result <= BP_OUT2;
                        end
                        Mul_enable <= 1'b0;
                        SQA_opt    <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_WB;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    alu_seq_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (dst_q),
        .wdata   (result),
        .rd_en   (accept),
        .srca    (instr_srca),
        .srcb    (instr_srcb),
        .da      (DA),
        .db      (DB),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameters SHALL be: MUL_LAT, 164, cycles from issue to valid BP_OUT1; SQA_LAT, 2, cycles from issue to valid BP_OUT2; SS_LAT, 2, cycles from issue to valid SS_OUT.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-006 instr_op  input  3  opcode: 0 LOAD, 1 MUL, 2 ADD, 3 SQADD, 4 SQSQ, 5-7 illegal.
REQ-007 instr_dst / instr_srca / instr_srcb  input  3 each  register indices R0-R7.
REQ-008 load_data  input  163  GF(2^163) operand for LOAD.
REQ-009 done  output  1  one-cycle pulse on instruction retirement.
REQ-010 err_illegal  output  1  qualifies done; high when the retired opcode was illegal.
REQ-011 rd_addr  input  3 / rd_data  output  163  combinational host read port.
REQ-012 DA, DB  output  163 each  operands to ALU.
REQ-013 Mul_enable  output  1 / SQA_opt  output  1  ALU controls.
REQ-014 BP_OUT1, BP_OUT2, SS_OUT  input  163 each  ALU results (mul, square-add, double-square).

Function
REQ-015 Register bank SHALL be 8 x 163-bit; only write sources are LOAD and ALU writeback.
REQ-016 FSM states SHALL be IDLE, EXEC, WB; instr_ready high only in IDLE and not in reset.
REQ-017 Accept (instr_valid & instr_ready) SHALL latch op/dst and drive DA=R[srca], DB=R[srcb] from registered copies, held stable until WB completes.
REQ-018 LOAD: IDLE -> WB next cycle, R[dst] <= load_data (latched at accept); retire latency 2 cycles from accept.
REQ-019 MUL: Mul_enable high from cycle after accept through the capture cycle; BP_OUT1 captured after MUL_LAT EXEC cycles.
REQ-020 ADD/SQADD: SQA_opt=0/1 respectively, held through EXEC; BP_OUT2 captured after SQA_LAT cycles.
REQ-021 SQSQ: DB=R[srcb]; SS_OUT captured after SS_LAT cycles; DA don't-care but held.
REQ-022 EXEC countdown SHALL load LAT-1 at accept and transition to WB when zero; WB writes R[dst], pulses done, returns to IDLE.
REQ-023 Mul_enable and SQA_opt SHALL be 0 outside their own EXEC windows.
REQ-024 Illegal opcode: no register write, IDLE -> WB -> IDLE, done=1 with err_illegal=1.
REQ-025 dst equal to srca/srcb SHALL be legal; operands already latched, result overwrites.
REQ-026 rd_data SHALL show pre-write value during WB cycle and new value the following cycle.
REQ-027 instr_valid while busy: held off by instr_ready=0; no instruction lost or duplicated.

Reset
REQ-028 On rst: state IDLE, counter 0, all registers 0, DA=DB=0, Mul_enable=0, SQA_opt=0, done=0, err_illegal=0; instr_ready=0 during the rst cycle.
REQ-029 rst mid-EXEC or WB SHALL abort without writeback and without done.

Structure
REQ-030 Package alu_seq_pkg SHALL hold FIELD_W=163, opcode constants, state encoding, register-index width.
REQ-031 Register bank SHALL be sub-module alu_seq_regfile (one write port, two registered operand reads, one combinational read).

Verification
REQ-032 LOAD R1=163'h5, LOAD R2=163'h3 -> done after 2 cycles each; rd_addr=1 gives 163'h5.
REQ-033 ADD R3=R1+R2 with SQA_LAT=2, model BP_OUT2=DA^DB -> R3=163'h6, SQA_opt=0 throughout, done at accept+3.
REQ-034 MUL R4=R1*R2, model returns 163'hF after MUL_LAT -> Mul_enable high exactly MUL_LAT cycles, R4=163'hF, no done earlier.
REQ-035 instr_valid held high with back-to-back ADD, SQSQ -> second accepted only in cycle after first done; both results written.
REQ-036 rst asserted mid-MUL -> no done, R4 unchanged (0 after reset), Mul_enable 0 next cycle.
REQ-037 opcode 6 -> done=1, err_illegal=1, all registers unchanged.
